pool_fmap_buffer: RTL and testbench

Ping-pong feature-map buffer directly downstream of the max-pooling stage. It captures the pooled results that the pooler emits as (strobe, addr, data) into one of two MAP×MAP banks. It then streams each completed bank in raster order to the next convolution layer over a valid/ready handshake. While one bank drains, the other fills, so the pooler never has to stall for a full frame.

---
 rtl/pool_fmap_buffer_if.sv | 32 +++
 rtl/pool_fmap_buffer.sv | 166 ++++++++++++++++
 tb/tb_pool_fmap_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_fmap_buffer_if.sv
// Stream bundle between the pooler, the ping-pong feature-map buffer and the
// next convolution layer: a strobe-only write side carrying pooled results in,
// and a valid/ready read side streaming each finished map out in raster order.
interface pool_fmap_buffer_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  // Write side (pooler -> buffer)
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          in_ready;

  // Read side (buffer -> next layer)
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  // The buffer itself
  modport slave (
    input  wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  // The surrounding pipeline: pooler on the write side, consumer on the read side
  modport master (
    output wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/pool_fmap_buffer.sv
// Ping-pong feature-map buffer behind the max-pooling stage. Pooled results are
// written by raster address into the free bank; once a bank has received ENT
// writes it is marked full and streamed out in raster order while the other
// bank fills. Drops are flagged by two sticky error bits.
module pool_fmap_buffer #(
  parameter int DW  = 16,
  parameter int MAP = 4,
  parameter int AW  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  pool_fmap_buffer_if.slave   bus,
  output logic [1:0]          bank_full,
  output logic                overflow,
  output logic                addr_err
);

  localparam int            ENT      = MAP * MAP;
  localparam int            IW       = (ENT > 1) ? $clog2(ENT) : 1;
  localparam logic [AW:0]   ENT_W    = (AW + 1)'(ENT);
  localparam logic [AW-1:0] LAST_IDX = AW'(ENT - 1);

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_e;

  // Both banks share one array; the bank select is the top index bit.
  // NOTE: the storage array is deliberately not reset: its contents are only
  // ever read after a full set of writes, so a reset port would buy nothing.
  logic [DW-1:0] mem [2**(IW+1)];

  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_cnt;
  logic          in_ready;
  logic          addr_ok;
  logic          wr_accept;
  logic          wr_complete;

  rd_state_e     state_q, state_d;
  logic          load;
  logic [AW-1:0] load_idx;
  logic          rd_release;

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_idx_q;
  logic          out_last_q;

  assign addr_ok     = {1'b0, bus.wr_addr} < ENT_W;
  assign in_ready    = !bank_full[wr_bank];
  assign wr_accept   = bus.wr_en && in_ready && addr_ok;
  assign wr_complete = wr_accept && (wr_cnt == LAST_IDX);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

  // Capture accepted pooled results into the current write bank.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_bank, bus.wr_addr[IW-1:0]}] <= bus.wr_data;
    end
  end

  // Write-side bookkeeping: write count, bank toggle and sticky drop flags.
  // NOTE: every clocked register uses non-blocking assignment so all state
  // updates see the pre-edge values, matching flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_complete) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + AW'(1);
        end
      end
      // An out-of-range address is reported as such even when no bank is free.
      if (bus.wr_en && !addr_ok) begin
        addr_err <= 1'b1;
      end
      if (bus.wr_en && addr_ok && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Full flags: set by the write side, cleared by the read side. They never
  // name the same bank on one edge, so the two updates are independent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_complete) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read FSM next-state and element-load decisions.
  // NOTE: all outputs of this block get a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_idx   = '0;
    rd_release = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (bank_full[rd_bank]) begin
          load    = 1'b1;
          state_d = R_SEND;
        end
      end
      R_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            rd_release = 1'b1;
            state_d    = R_IDLE;
          end else begin
            load     = 1'b1;
            load_idx = out_idx_q + AW'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read state register and registered output element; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= R_IDLE;
      rd_bank     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem[{rd_bank, load_idx[IW-1:0]}];
        out_idx_q   <= load_idx;
        out_last_q  <= (load_idx == LAST_IDX);
      end else if (rd_release) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        rd_bank     <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Self-checking bench for pool_fmap_buffer. The reference model tracks frames
// as whole arrays: a completed frame is pushed onto an expected-beat queue and
// the number of frames waiting decides whether a write may land.
module tb_pool_fmap_buffer;

  localparam int DW  = 16;
  localparam int MAP = 4;
  localparam int AW  = 6;
  localparam int ENT = MAP * MAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bank_full;
  logic       overflow;
  logic       addr_err;

  pool_fmap_buffer_if #(.DW(DW), .AW(AW)) bus ();

  pool_fmap_buffer #(.DW(DW), .MAP(MAP), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .bank_full (bank_full),
    .overflow  (overflow),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
    int            cyc;
  } beat_t;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DW-1:0] m_mem [2][ENT];
  bit            m_wbank;
  int            m_cnt, m_pend, m_beats_out, m_done_cyc;
  bit            m_ovf, m_aerr;
  beat_t         exp_q[$];
  beat_t         obs_q[$];
  int            cyc = 0;
  int            stall_bad, ir_bad;
  bit            prev_stall;
  beat_t         prev_beat;
  logic [DW-1:0] frm [ENT];

  task automatic model_reset();
    m_wbank = 1'b0; m_cnt = 0; m_pend = 0; m_beats_out = 0;
    m_ovf = 1'b0; m_aerr = 1'b0;
    exp_q.delete(); obs_q.delete();
    stall_bad = 0; ir_bad = 0; prev_stall = 1'b0;
  endtask

  function automatic bit rdy_for(int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return 1'b0;
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later, advance
  // the model at the rising edge, return at the next falling edge.
  task automatic cycle(input bit we, input int a, input logic [DW-1:0] d, input bit rdy);
    bit    xfer;
    beat_t b;
    bus.wr_en = we; bus.wr_addr = AW'(a); bus.wr_data = d; bus.out_ready = rdy;
    #1;
    if (bus.in_ready !== (m_pend < 2)) ir_bad++;
    if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_beat.data ||
        bus.out_idx !== prev_beat.idx || bus.out_last !== prev_beat.last)) stall_bad++;
    xfer   = (bus.out_valid === 1'b1) && rdy;
    b.data = bus.out_data; b.idx = bus.out_idx; b.last = bus.out_last; b.cyc = cyc;
    if (xfer) obs_q.push_back(b);
    prev_stall = (bus.out_valid === 1'b1) && !rdy;
    prev_beat  = b;
    @(posedge clk);
    if (we) begin
      if (a >= ENT) m_aerr = 1'b1;
      else if (m_pend >= 2) m_ovf = 1'b1;
      else begin
        m_mem[m_wbank][a] = d;
        m_cnt++;
        if (m_cnt == ENT) begin
          for (int i = 0; i < ENT; i++)
            exp_q.push_back('{data: m_mem[m_wbank][i], idx: AW'(i), last: (i == ENT - 1), cyc: 0});
          m_pend++; m_wbank = !m_wbank; m_cnt = 0; m_done_cyc = cyc;
        end
      end
    end
    if (xfer) begin
      m_beats_out++;
      if (m_beats_out % ENT == 0) m_pend--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_frame(input int mode);
    for (int i = 0; i < ENT; i++) cycle(1'b1, i, frm[i], rdy_for(mode));
  endtask

  task automatic drain(input int max_cycles, input int mode);
    int n = 0;
    while ((obs_q.size() < exp_q.size() || m_pend != 0) && n < max_cycles) begin
      cycle(1'b0, 0, '0, rdy_for(mode));
      n++;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < ENT; i++) frm[i] = DW'($urandom_range(100, 65535));
  endtask

  // Index of the first observed beat that differs from the model, or -1.
  function automatic int first_bad_beat();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].idx !== exp_q[i].idx ||
          obs_q[i].last !== exp_q[i].last) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_en = (i == 0); bus.wr_addr = AW'($urandom_range(0, ENT - 1));
      bus.wr_data = DW'($urandom); bus.out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    tests_run++;
    if ({bus.out_valid, bus.out_last, overflow, addr_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid/last/ovf/aerr=%b, expected 0000",
               {bus.out_valid, bus.out_last, overflow, addr_err});
    end
    tests_run++;
    if (bus.out_data !== '0 || bus.out_idx !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got data=%0d idx=%0d, expected 0/0", bus.out_data, bus.out_idx);
    end
    tests_run++;
    if (bank_full !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_bank_full: got %b, expected 00", bank_full);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    bus.wr_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_frame();
    frm = '{16'd45, 16'd27, 16'd40, 16'd44, 16'd15, 16'd50, 16'd38, 16'd58,
            16'd28, 16'd25, 16'd31, 16'd36, 16'd39, 16'd30, 16'd40, 16'd34};
    send_frame(0);
    tests_run++;
    if (bank_full !== 2'b01 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_complete: got bank_full=%b valid=%b, expected 01/0", bank_full, bus.out_valid);
    end
    cycle(1'b0, 0, '0, 1'b1);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== '0 || bus.out_data !== 16'd45) begin
      tests_failed++;
      $display("FAIL single_first: got valid=%b idx=%0d data=%0d, expected 1/0/45",
               bus.out_valid, bus.out_idx, bus.out_data);
    end
    drain(40, 0);
    tests_run++;
    if (obs_q.size() !== ENT) begin
      tests_failed++;
      $display("FAIL single_count: got %0d beats, expected %0d", obs_q.size(), ENT);
    end
    tests_run++;
    if (first_bad_beat() !== -1) begin
      tests_failed++;
      $display("FAIL single_values: got mismatch at beat %0d, expected none", first_bad_beat());
    end
    begin
      int gaps = 0;
      for (int i = 0; i < obs_q.size(); i++)
        if (obs_q[i].cyc != m_done_cyc + 2 + i) gaps++;
      tests_run++;
      if (gaps !== 0) begin
        tests_failed++;
        $display("FAIL single_timing: got %0d beats off the 1-per-cycle schedule, expected 0", gaps);
      end
    end
    tests_run++;
    if (bank_full !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_released: got bank_full=%b, expected 00", bank_full);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    frm = '{16'd45, 16'd27, 16'd40, 16'd44, 16'd15, 16'd50, 16'd38, 16'd58,
            16'd28, 16'd25, 16'd31, 16'd36, 16'd39, 16'd30, 16'd40, 16'd34};
    send_frame(1);
    drain(100, 1);
    tests_run++;
    if (obs_q.size() !== ENT) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d transfers, expected %0d", obs_q.size(), ENT);
    end
    tests_run++;
    if (first_bad_beat() !== -1) begin
      tests_failed++;
      $display("FAIL bp_values: got mismatch at beat %0d, expected none", first_bad_beat());
    end
    tests_run++;
    if (stall_bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d unstable stall cycles, expected 0", stall_bad);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pingpong_overflow();
    random_frame(); send_frame(2);
    random_frame(); send_frame(2);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bank_full !== 2'b11) begin
      tests_failed++;
      $display("FAIL pp_both_full: got in_ready=%b bank_full=%b, expected 0/11", bus.in_ready, bank_full);
    end
    cycle(1'b1, 3, 16'h1234, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL pp_overflow: got %b, expected 1", overflow);
    end
    drain(100, 0);
    tests_run++;
    if (obs_q.size() !== 2 * ENT || first_bad_beat() !== -1) begin
      tests_failed++;
      $display("FAIL pp_order: got %0d beats, first bad %0d, expected %0d beats, none bad",
               obs_q.size(), first_bad_beat(), 2 * ENT);
    end
    tests_run++;
    if (ir_bad !== 0 || bank_full !== 2'b00) begin
      tests_failed++;
      $display("FAIL pp_ready: got %0d in_ready errors, bank_full=%b, expected 0/00", ir_bad, bank_full);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_addr_err();
    logic [1:0] exp_bf;
    int         seen99 = 0;
    exp_bf = 2'b01 << m_wbank;
    random_frame();
    for (int i = 0; i < 8; i++) cycle(1'b1, i, frm[i], 1'b1);
    cycle(1'b1, 16, 16'd99, 1'b1);
    for (int i = 8; i < ENT - 1; i++) cycle(1'b1, i, frm[i], 1'b1);
    tests_run++;
    if (addr_err !== 1'b1 || bank_full !== 2'b00) begin
      tests_failed++;
      $display("FAIL aerr_not_counted: got addr_err=%b bank_full=%b, expected 1/00", addr_err, bank_full);
    end
    cycle(1'b1, ENT - 1, frm[ENT-1], 1'b1);
    tests_run++;
    if (bank_full !== exp_bf) begin
      tests_failed++;
      $display("FAIL aerr_complete: got bank_full=%b, expected %b", bank_full, exp_bf);
    end
    drain(40, 0);
    foreach (obs_q[i]) if (obs_q[i].data === 16'd99) seen99++;
    tests_run++;
    if (obs_q.size() !== ENT || first_bad_beat() !== -1 || seen99 !== 0) begin
      tests_failed++;
      $display("FAIL aerr_stream: got %0d beats, first bad %0d, %0d x 99, expected %0d/none/0",
               obs_q.size(), first_bad_beat(), seen99, ENT);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    random_frame(); send_frame(2);
    while (obs_q.size() < 5 && n < 40) begin
      cycle(1'b0, 0, '0, 1'b1);
      n++;
    end
    tests_run++;
    if (bus.out_idx !== AW'(5) || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_position: got idx=%0d valid=%b, expected 5/1", bus.out_idx, bus.out_valid);
    end
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bank_full !== 2'b00 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: got valid=%b bank_full=%b in_ready=%b, expected 0/00/1",
               bus.out_valid, bank_full, bus.in_ready);
    end
    model_reset();
    random_frame(); send_frame(2);
    tests_run++;
    if (bank_full !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_fresh_bank: got bank_full=%b, expected 01", bank_full);
    end
    drain(40, 0);
    tests_run++;
    if (obs_q.size() !== ENT || first_bad_beat() !== -1) begin
      tests_failed++;
      $display("FAIL mid_fresh_stream: got %0d beats, first bad %0d, expected %0d/none",
               obs_q.size(), first_bad_beat(), ENT);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(ENT, 2**AW - 1))
                                       : int'($urandom_range(0, ENT - 1));
      cycle($urandom_range(0, 3) != 0, a, DW'($urandom), $urandom_range(0, 2) != 0);
    end
    drain(200, 0);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (first_bad_beat() !== -1) begin
      tests_failed++;
      $display("FAIL rand_values: got mismatch at beat %0d, expected none", first_bad_beat());
    end
    tests_run++;
    if (stall_bad !== 0 || ir_bad !== 0) begin
      tests_failed++;
      $display("FAIL rand_handshake: got %0d stall / %0d in_ready errors, expected 0/0", stall_bad, ir_bad);
    end
    tests_run++;
    if (overflow !== m_ovf || addr_err !== m_aerr) begin
      tests_failed++;
      $display("FAIL rand_flags: got ovf=%b aerr=%b, expected %b/%b", overflow, addr_err, m_ovf, m_aerr);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_pingpong_overflow();
    test_addr_err();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
